// File: rtl/buyruk_onbellek.sv
// Direct-mapped, one-word-per-line instruction cache in front of a variable-latency
// instruction memory; hits are combinational, misses stall the core until the fill lands.
module buyruk_onbellek #(
  parameter int unsigned SATIR_SAYISI = 16,
  parameter logic [31:0] NOP          = 32'h0000_0013
) (
  input  logic        saat,
  input  logic        reset,
  input  logic [31:0] ps,
  input  logic        temizle,
  output logic [31:0] buyruk,
  output logic        buyruk_gecerli,
  output logic        hizasiz,
  output logic        bellek_istek,
  output logic [31:0] bellek_adres,
  input  logic        bellek_hazir,
  input  logic [31:0] bellek_veri,
  output logic [31:0] isabet_sayisi,
  output logic [31:0] iskalama_sayisi
);

  localparam int unsigned I        = $clog2(SATIR_SAYISI);
  localparam int unsigned ETIKET_W = 30 - I;

  typedef enum logic {
    BOS,
    ISTEK
  } durum_t;

  durum_t                r_durum;
  durum_t                w_sonraki;
  logic [SATIR_SAYISI-1:0] r_gecerli;
  logic [ETIKET_W-1:0]   r_etiket [SATIR_SAYISI];
  logic [31:0]           r_veri   [SATIR_SAYISI];
  logic                  r_iptal;
  logic                  r_istek;
  logic [31:0]           r_adres;
  logic [31:0]           r_isabet;
  logic [31:0]           r_iskalama;

  logic [I-1:0]          w_indeks;
  logic [ETIKET_W-1:0]   w_etiket;
  logic [I-1:0]          w_dolum_indeks;
  logic [ETIKET_W-1:0]   w_dolum_etiket;
  logic                  w_hizasiz;
  logic                  w_isabet;
  logic                  w_iskalama;
  logic                  w_dolum_bitti;

  // Lookup uses the live PC; the fill side uses the address latched at the miss.
  assign w_indeks       = ps[I+1:2];
  assign w_etiket       = ps[31:I+2];
  assign w_dolum_indeks = r_adres[I+1:2];
  assign w_dolum_etiket = r_adres[31:I+2];
  assign w_hizasiz      = |ps[1:0];

  assign w_isabet      = (r_durum == BOS) && !w_hizasiz && r_gecerli[w_indeks]
                         && (r_etiket[w_indeks] == w_etiket);
  assign w_iskalama    = (r_durum == BOS) && !w_hizasiz && !w_isabet;
  assign w_dolum_bitti = (r_durum == ISTEK) && bellek_hazir;

  assign hizasiz         = w_hizasiz;
  assign buyruk_gecerli  = w_isabet;
  assign buyruk          = w_isabet ? r_veri[w_indeks] : NOP;
  assign bellek_istek    = r_istek;
  assign bellek_adres    = r_adres;
  assign isabet_sayisi   = r_isabet;
  assign iskalama_sayisi = r_iskalama;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      r_durum <= BOS;
    end else begin
      r_durum <= w_sonraki;
    end
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves w_sonraki unassigned (no latch).
    w_sonraki = r_durum;
    case (r_durum)
      BOS:     if (w_iskalama)    w_sonraki = ISTEK;
      ISTEK:   if (bellek_hazir)  w_sonraki = BOS;
      default:                    w_sonraki = BOS;
    endcase
  end

  // Fill request: raised on the miss edge, held with its address until the ready edge.
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      r_istek <= 1'b0;
      r_adres <= '0;
    end else if (w_iskalama) begin
      r_istek <= 1'b1;
      r_adres <= {ps[31:2], 2'b00};
    end else if (w_dolum_bitti) begin
      r_istek <= 1'b0;
    end
  end

  // A flush during an outstanding fill must keep that fill from reviving its line.
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      r_iptal <= 1'b0;
    end else if (w_dolum_bitti) begin
      r_iptal <= 1'b0;
    end else if (temizle && (r_durum == ISTEK)) begin
      r_iptal <= 1'b1;
    end
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      r_gecerli <= '0;
    end else if (temizle) begin
      r_gecerli <= '0;
    end else if (w_dolum_bitti && !r_iptal) begin
      r_gecerli[w_dolum_indeks] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether they are read.
  always_ff @(posedge saat) begin
    if (w_dolum_bitti) begin
      r_etiket[w_dolum_indeks] <= w_dolum_etiket;
      r_veri[w_dolum_indeks]   <= bellek_veri;
    end
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      r_isabet   <= '0;
      r_iskalama <= '0;
    end else begin
      if (w_isabet)   r_isabet   <= r_isabet + 32'd1;
      if (w_iskalama) r_iskalama <= r_iskalama + 32'd1;
    end
  end

endmodule

// File: tb/tb_buyruk_onbellek.sv
// Scoreboard bench for buyruk_onbellek: the driver predicts each fetch from a line-address
// model and queues the expected word; a monitor compares whenever the cache presents a word.
module tb_buyruk_onbellek;

  localparam int unsigned SATIR = 16;
  localparam logic [31:0] NOPW  = 32'h0000_0013;

  logic        saat = 1'b0;
  logic        reset;
  logic [31:0] ps;
  logic        temizle;
  logic [31:0] buyruk;
  logic        buyruk_gecerli;
  logic        hizasiz;
  logic        bellek_istek;
  logic [31:0] bellek_adres;
  logic        bellek_hazir;
  logic [31:0] bellek_veri;
  logic [31:0] isabet_sayisi;
  logic [31:0] iskalama_sayisi;

  buyruk_onbellek #(.SATIR_SAYISI(SATIR), .NOP(NOPW)) dut (
    .saat            (saat),
    .reset           (reset),
    .ps              (ps),
    .temizle         (temizle),
    .buyruk          (buyruk),
    .buyruk_gecerli  (buyruk_gecerli),
    .hizasiz         (hizasiz),
    .bellek_istek    (bellek_istek),
    .bellek_adres    (bellek_adres),
    .bellek_hazir    (bellek_hazir),
    .bellek_veri     (bellek_veri),
    .isabet_sayisi   (isabet_sayisi),
    .iskalama_sayisi (iskalama_sayisi)
  );

  always #5 saat = ~saat;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: which word address each line holds, plus expected counter values.
  bit          m_gecerli [SATIR];
  logic [31:0] m_adres   [SATIR];
  int unsigned exp_hit  = 0;
  int unsigned exp_miss = 0;
  logic [31:0] beklenen_q [$];

  logic [31:0] bellek [logic [31:0]];
  bit          otomatik = 1'b0;
  int          gecikme  = -1;

  task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    n_vec++;
    if (gercek !== beklenen) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", ad, gercek, beklenen, $time);
    end
  endtask

  function automatic logic [31:0] bellek_oku(input logic [31:0] a);
    if (!bellek.exists(a)) bellek[a] = $urandom;
    return bellek[a];
  endfunction

  function automatic void model_temizle();
    for (int i = 0; i < SATIR; i++) m_gecerli[i] = 1'b0;
  endfunction

  // Memory responder: in automatic mode answers each request after 'gecikme' extra cycles.
  initial begin
    int bekle;
    bit aktif;
    bekle = 0;
    aktif = 1'b0;
    forever begin
      @(posedge saat);
      #1;
      if (otomatik) begin
        bellek_hazir = 1'b0;
        if (bellek_istek && !reset) begin
          if (!aktif) begin
            aktif = 1'b1;
            bekle = (gecikme < 0) ? int'($urandom_range(0, 3)) : gecikme;
          end
          if (bekle == 0) begin
            bellek_hazir = 1'b1;
            bellek_veri  = bellek_oku(bellek_adres);
            aktif        = 1'b0;
          end else begin
            bekle--;
          end
        end else begin
          aktif = 1'b0;
        end
      end
    end
  end

  // Monitor: every presented word must match the head of the scoreboard; otherwise NOP.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge saat);
      if (buyruk_gecerli) begin
        if (beklenen_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got %08h with no fetch pending (t=%0t)", buyruk, $time);
        end else begin
          e = beklenen_q.pop_front();
          check("buyruk", buyruk, e);
        end
      end else begin
        check("buyruk_nop", buyruk, NOPW);
      end
    end
  end

  task automatic sayac_kontrol(input string ad);
    check({ad, "_isabet"},   isabet_sayisi,   exp_hit);
    check({ad, "_iskalama"}, iskalama_sayisi, exp_miss);
  endtask

  // One fetch: predict hit/miss, queue the expected word, hold ps until the cache delivers.
  task automatic getir(input logic [31:0] a);
    int  idx;
    int  n;
    bit  isabet_bek;
    idx        = int'((a / 4) % SATIR);
    isabet_bek = m_gecerli[idx] && (m_adres[idx] == a);
    if (!isabet_bek) begin
      exp_miss++;
      m_gecerli[idx] = 1'b1;
      m_adres[idx]   = a;
    end
    exp_hit++;
    beklenen_q.push_back(bellek_oku(a));
    ps = a;
    @(negedge saat);
    if (isabet_bek) begin
      check("hit_same_cycle", {31'd0, buyruk_gecerli}, 32'd1);
    end else begin
      check("miss_stall", {31'd0, buyruk_gecerli}, 32'd0);
      @(negedge saat);
      check("miss_request", {31'd0, bellek_istek}, 32'd1);
      check("miss_address", bellek_adres, {a[31:2], 2'b00});
      n = 0;
      while (!buyruk_gecerli && n < 40) begin
        @(negedge saat);
        n++;
      end
      check("fill_timeout", {31'd0, buyruk_gecerli}, 32'd1);
    end
    @(posedge saat);
    #1;
  endtask

  task automatic temizle_darbe();
    ps      = 32'h0000_0002;
    temizle = 1'b1;
    @(posedge saat);
    #1;
    temizle = 1'b0;
    model_temizle();
  endtask

  logic [31:0] etiketler [4];

  initial begin
    int n;
    reset        = 1'b1;
    ps           = 32'h0000_0002;
    temizle      = 1'b0;
    bellek_hazir = 1'b0;
    bellek_veri  = '0;
    model_temizle();
    bellek[32'h0] = 32'h0070_0313;

    // Reset state, sampled while reset is still held.
    ps = 32'h0;
    repeat (2) @(posedge saat);
    #1;
    check("rst_gecerli", {31'd0, buyruk_gecerli}, 32'd0);
    check("rst_buyruk", buyruk, NOPW);
    check("rst_istek", {31'd0, bellek_istek}, 32'd0);
    check("rst_adres", bellek_adres, 32'd0);
    sayac_kontrol("rst");
    ps    = 32'h0000_0002;
    reset = 1'b0;

    // Cold fetch with memory answering in the third request cycle.
    otomatik = 1'b1;
    gecikme  = 2;
    getir(32'h0);
    sayac_kontrol("cold");

    // Hit streak over three preloaded words.
    gecikme = -1;
    getir(32'h4);
    getir(32'h8);
    for (int i = 0; i < 3; i++) getir(32'(i * 4));
    check("streak_istek", {31'd0, bellek_istek}, 32'd0);
    sayac_kontrol("streak");

    // Conflict eviction on index 0.
    getir(32'h40);
    getir(32'h0);
    sayac_kontrol("conflict");

    // Misaligned fetch: no fill, no counting.
    ps = 32'h6;
    @(negedge saat);
    check("mis_hizasiz", {31'd0, hizasiz}, 32'd1);
    check("mis_buyruk", buyruk, NOPW);
    repeat (2) @(posedge saat);
    #1;
    check("mis_istek", {31'd0, bellek_istek}, 32'd0);
    sayac_kontrol("mis");

    // Flush while idle, then refetch misses.
    temizle_darbe();
    getir(32'h0);
    sayac_kontrol("flush");

    // Flush during an outstanding fill: fill completes but the line stays invalid.
    temizle_darbe();
    otomatik = 1'b0;
    ps = 32'h0;
    exp_miss++;
    @(posedge saat);
    #1;
    check("midflush_istek", {31'd0, bellek_istek}, 32'd1);
    temizle = 1'b1;
    @(posedge saat);
    #1;
    temizle = 1'b0;
    @(posedge saat);
    #1;
    bellek_hazir = 1'b1;
    bellek_veri  = bellek_oku(32'h0);
    @(posedge saat);
    #1;
    bellek_hazir = 1'b0;
    @(negedge saat);
    check("midflush_istek_dustu", {31'd0, bellek_istek}, 32'd0);
    check("midflush_gecersiz", {31'd0, buyruk_gecerli}, 32'd0);
    @(posedge saat);
    #1;
    exp_miss++;
    check("midflush_yeniden", {31'd0, bellek_istek}, 32'd1);
    check("midflush_adres", bellek_adres, 32'h0);
    m_gecerli[0] = 1'b1;
    m_adres[0]   = 32'h0;
    exp_hit++;
    beklenen_q.push_back(bellek_oku(32'h0));
    otomatik = 1'b1;
    n = 0;
    while (!buyruk_gecerli && n < 40) begin
      @(negedge saat);
      n++;
    end
    check("midflush_timeout", {31'd0, buyruk_gecerli}, 32'd1);
    @(posedge saat);
    #1;
    sayac_kontrol("midflush");

    // Reset during a fill: request drops without an edge; a stray ready writes nothing.
    otomatik = 1'b0;
    ps = 32'h100;
    @(posedge saat);
    #1;
    check("rstfill_istek", {31'd0, bellek_istek}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstfill_async", {31'd0, bellek_istek}, 32'd0);
    model_temizle();
    exp_hit  = 0;
    exp_miss = 0;
    sayac_kontrol("rstfill");
    @(posedge saat);
    #1;
    reset        = 1'b0;
    ps           = 32'h0000_0002;
    bellek_hazir = 1'b1;
    bellek_veri  = 32'hDEAD_BEEF;
    @(posedge saat);
    #1;
    bellek_hazir = 1'b0;
    otomatik     = 1'b1;
    getir(32'h100);
    sayac_kontrol("stray");

    // Randomised traffic over a few tags sharing the same indices, with occasional flushes.
    etiketler[0] = 32'h0000_0000;
    etiketler[1] = 32'h0000_0040;
    etiketler[2] = 32'h0000_0080;
    etiketler[3] = 32'hFFFF_FFC0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) < 4) begin
        temizle_darbe();
      end else begin
        getir(etiketler[$urandom_range(0, 3)] | (32'($urandom_range(0, SATIR - 1)) << 2));
      end
    end
    ps = 32'h0000_0002;
    repeat (2) @(posedge saat);
    #1;
    sayac_kontrol("random");
    check("queue_empty", 32'(beklenen_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buyruk_onbellek.md
# buyruk_onbellek

Direct-mapped instruction cache between the single-cycle core and the external instruction memory. It takes the core's program counter `ps` and returns `buyruk` in the same cycle on a hit. On a miss it stalls the core via `buyruk_gecerli` and fills the line over a request/ready handshake with a variable-latency memory. It also provides invalidation (fence.i) and hit/miss counters for performance bring-up.

## Interface
- `SATIR_SAYISI`, 16: number of one-word lines; power of two, ≥2.
- `NOP`, 32'h0000_0013: word driven on `buyruk` when not valid (addi x0,x0,0).
- `saat`  in  1  clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ps`  in  32  fetch address from core.
- `temizle`  in  1  invalidate all lines (sampled at edge).
- `buyruk`  out  32  instruction for `ps`; `NOP` when `buyruk_gecerli`=0.
- `buyruk_gecerli`  out  1  `buyruk` is valid; core must hold `ps` while 0.
- `hizasiz`  out  1  `ps[1:0]`≠0 (combinational).
- `bellek_istek`  out  1  fill request to memory.
- `bellek_adres`  out  32  word-aligned fill address.
- `bellek_hazir`  in  1  memory data valid this cycle.
- `bellek_veri`  in  32  fill data.
- `isabet_sayisi`  out  32  hit count.
- `iskalama_sayisi`  out  32  miss count.

## Operation
- Address split, with I = log2(SATIR_SAYISI): index = `ps[I+1:2]`, tag = `ps[31:I+2]`. Storage per line is a valid bit, a tag and 32 data bits.
- FSM states: BOS (idle/lookup) and ISTEK (fill outstanding).
- Hit is true when state = BOS, `hizasiz`=0, valid[index]=1 and tag matches. On a hit, `buyruk` = data[index] and `buyruk_gecerli`=1, both combinationally.
- Miss: state BOS, aligned, no hit.
  - Next edge: go to ISTEK.
  - Latch `bellek_adres` = {`ps[31:2]`,2'b00}.
  - Assert `bellek_istek` (registered).
  - Increment `iskalama_sayisi`.
- ISTEK:
  - `bellek_istek` and `bellek_adres` are held stable.
  - `buyruk_gecerli`=0.
  - On an edge with `bellek_hazir`=1, write tag/data of the latched address and set valid, unless the cancel flag `iptal` is set. Then drop `bellek_istek`, clear `iptal` and return to BOS.
  - `bellek_hazir` is ignored in BOS.
- Misaligned `ps`: `buyruk`=NOP, `buyruk_gecerli`=0, `hizasiz`=1. No fill starts and no counter changes.
- `temizle`=1 at an edge:
  - Clears all valid bits.
  - In ISTEK, also sets `iptal`. The in-flight fill still completes the handshake but does not set valid.
  - If `bellek_hazir` and `temizle` occur on the same edge, the line is left invalid.
- `isabet_sayisi` increments on every edge where hit=1. Both counters wrap modulo 2^32.
- Conflict: a fill overwrites whatever line occupies the index (no replacement choice).

## Timing
- Reset (asynchronous) sets:
  - all valid = 0 and state = BOS
  - `bellek_istek`=0 and `bellek_adres`=0
  - `iptal`=0
  - both counters = 0
- During reset, `buyruk`=NOP and `buyruk_gecerli`=0.
- Hit latency is 0 cycles (combinational from `ps`).
- Miss penalty is L+1 cycles, where L = number of cycles `bellek_istek` is high up to and including the `bellek_hazir` edge. `buyruk_gecerli` rises the cycle after that edge.
- Minimum miss (ready in first ISTEK cycle): `buyruk_gecerli` low for 2 cycles.
- Reset asserted mid-fill: FSM aborts immediately and `bellek_istek` drops asynchronously. A later `bellek_hazir` is ignored.
- If `ps` changes during ISTEK (protocol violation), the fill still targets the latched address. The lookup re-evaluates the new `ps` in BOS.

## Test plan
- Cold fetch: reset, `ps`=0x0. Expect `buyruk_gecerli`=0, `bellek_istek`=1, `bellek_adres`=0x0. Memory answers after 3 cycles with 0x00700313. The next cycle gives `buyruk`=0x00700313, `buyruk_gecerli`=1, `iskalama_sayisi`=1.
- Hit streak: preload 0x0/0x4/0x8, then step `ps` over them for 3 cycles. Expect `buyruk_gecerli`=1 each cycle, `bellek_istek`=0, `isabet_sayisi` +3.
- Conflict eviction (16 lines): fill 0x00, then fetch 0x40. Expect a miss, index 0 replaced. Refetch 0x00 misses again; `iskalama_sayisi`=3.
- Invalidation: with 0x0 cached, pulse `temizle`, then fetch 0x0 → miss. Pulse `temizle` mid-fill with ready 2 cycles later: the fill completes, the line stays invalid, and a new request issues for 0x0.
- Reset mid-fill: assert `reset` while `bellek_istek`=1. `bellek_istek` drops without waiting for an edge and counters read 0. A stray `bellek_hazir` after release writes nothing.
- Misaligned: `ps`=0x6. Expect `hizasiz`=1, `buyruk`=0x00000013, `bellek_istek`=0, counters unchanged.
